// File: rtl/game_pkg.sv
// Shared game-flow types and default frame timing for the game logic and draw_* stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

    // State encoding seen by every draw_* overlay; compare against these names, not literals.
    typedef enum logic [2:0] {
        ST_MENU      = 3'b000,
        ST_COUNTDOWN = 3'b001,
        ST_PLAY      = 3'b010,
        ST_PAUSE     = 3'b011,
        ST_OVER      = 3'b100
    } game_state_t;

    // Default frame timings at 60 Hz.
    localparam int DEF_COUNTDOWN_FRAMES = 180;
    localparam int DEF_OVER_MIN_FRAMES  = 60;
    localparam int DEF_OVER_MAX_FRAMES  = 600;
    localparam int DEF_BLINK_FRAMES     = 30;
    localparam int DEF_CNT_W            = 10;

endpackage

// File: rtl/frame_tick_gen.sv
// Turns the vsync level into a one-cycle frame tick on its rising edge.
// Latency: tick is registered, high for one clk starting one clk after vsync is sampled high.
// Backpressure: none; every rising edge produces exactly one tick.
//
// Ports:
//   clk   - pixel clock
//   rst   - synchronous active-low reset, clears the edge history
//   vsync - vsync level from the VGA timing stage
//   tick  - one-cycle frame strobe
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic tick
);

    logic vsync_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            vsync_d <= 1'b0;
            tick    <= 1'b0;
        end else begin
            vsync_d <= vsync;
            tick    <= vsync & ~vsync_d;
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Central game-flow FSM: menu, countdown, play, pause, game-over, all timed in frames.
// Latency: inputs act on the next clk edge; all outputs registered (new state visible one clk later).
// Backpressure: none; button events are edge-detected and an event not consumed by a state is dropped.
//
// Ports:
//   clk, rst             - pixel clock, synchronous active-low reset
//   vsync                - frame timing, rising edge = frame tick
//   btn_start, btn_pause - debounced button levels (rising edge = one event)
//   player_dead          - level, high while no lives remain
//   game_state           - current game_state_t code
//   frame_cnt            - frames spent in the current state, saturating
//   over_blink           - blink phase while in OVER, 0 elsewhere
//   game_reset           - one-cycle pulse on the first COUNTDOWN cycle
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int COUNTDOWN_FRAMES = DEF_COUNTDOWN_FRAMES,
    parameter int OVER_MIN_FRAMES  = DEF_OVER_MIN_FRAMES,
    parameter int OVER_MAX_FRAMES  = DEF_OVER_MAX_FRAMES,
    parameter int BLINK_FRAMES     = DEF_BLINK_FRAMES,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vsync,
    input  logic             btn_start,
    input  logic             btn_pause,
    input  logic             player_dead,
    output logic [2:0]       game_state,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             over_blink,
    output logic             game_reset
);

    localparam int CNT_LIMIT = (1 << CNT_W) - 1;

    // Timing parameters must fit the frame counter, otherwise the equality compares never fire.
    if (COUNTDOWN_FRAMES < 1 || COUNTDOWN_FRAMES > CNT_LIMIT ||
        OVER_MIN_FRAMES  < 0 || OVER_MIN_FRAMES  > CNT_LIMIT ||
        OVER_MAX_FRAMES  < 1 || OVER_MAX_FRAMES  > CNT_LIMIT ||
        BLINK_FRAMES     < 1 || BLINK_FRAMES     > CNT_LIMIT) begin : g_bad_cfg
        $error("game_state_ctrl: frame parameter does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CD_LAST    = CNT_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [CNT_W-1:0] OVER_MIN   = CNT_W'(OVER_MIN_FRAMES);
    localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_MAX_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

    game_state_t      state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             over_blink_q, over_blink_d;
    logic             game_reset_q, game_reset_d;
    logic             btn_start_d, btn_pause_d;
    logic             tick;
    logic             start_ev, pause_ev;

    frame_tick_gen u_frame_tick (
        .clk   (clk),
        .rst   (rst),
        .vsync (vsync),
        .tick  (tick)
    );

    assign start_ev = btn_start & ~btn_start_d;
    assign pause_ev = btn_pause & ~btn_pause_d;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MENU: begin
                if (start_ev) state_d = ST_COUNTDOWN;
            end
            ST_COUNTDOWN: begin
                if (tick && frame_cnt_q == CD_LAST) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // Death wins over a pause pressed in the same cycle.
                if (player_dead)   state_d = ST_OVER;
                else if (pause_ev) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                // player_dead is intentionally not looked at here; PLAY picks it up next cycle.
                if (pause_ev || start_ev) state_d = ST_PLAY;
            end
            ST_OVER: begin
                // An early start press is simply dropped, never remembered.
                if (start_ev && frame_cnt_q >= OVER_MIN)    state_d = ST_COUNTDOWN;
                else if (tick && frame_cnt_q == OVER_LAST) state_d = ST_MENU;
            end
            default: state_d = ST_MENU;
        endcase
    end

    // Frame counter, blink phase and reset strobe, all derived from the transition just decided.
    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        blink_cnt_d  = blink_cnt_q;
        over_blink_d = over_blink_q;
        game_reset_d = (state_d == ST_COUNTDOWN) && (state_q != ST_COUNTDOWN);

        // A state change clears the count even if a tick lands in the same cycle.
        if (state_d != state_q) begin
            frame_cnt_d = '0;
        end else if (tick && frame_cnt_q != CNT_MAX) begin
            frame_cnt_d = frame_cnt_q + CNT_ONE;
        end

        // blink_cnt tracks frame_cnt modulo BLINK_FRAMES, so no divider is needed.
        if (state_d != ST_OVER || state_q != ST_OVER) begin
            blink_cnt_d  = '0;
            over_blink_d = 1'b0;
        end else if (tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d  = '0;
                over_blink_d = ~over_blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_MENU;
            frame_cnt_q  <= '0;
            blink_cnt_q  <= '0;
            over_blink_q <= 1'b0;
            game_reset_q <= 1'b0;
            btn_start_d  <= 1'b0;
            btn_pause_d  <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            over_blink_q <= over_blink_d;
            game_reset_q <= game_reset_d;
            btn_start_d  <= btn_start;
            btn_pause_d  <= btn_pause;
        end
    end

    assign game_state = state_q;
    assign frame_cnt  = frame_cnt_q;
    assign over_blink = over_blink_q;
    assign game_reset = game_reset_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios followed by randomized stimulus.
// Latency: expected outputs are queued per cycle and checked one clk later.
// Backpressure: n/a.
module tb_game_state_ctrl;

    localparam int CD    = 3;
    localparam int OMIN  = 2;
    localparam int OMAX  = 5;
    localparam int BLINK = 2;
    localparam int CNT_W = 3;
    localparam int MAXC  = (1 << CNT_W) - 1;

    localparam int S_MENU = 0, S_CD = 1, S_PLAY = 2, S_PAUSE = 3, S_OVER = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             vsync = 1'b0;
    logic             btn_start = 1'b0;
    logic             btn_pause = 1'b0;
    logic             player_dead = 1'b0;
    logic [2:0]       game_state;
    logic [CNT_W-1:0] frame_cnt;
    logic             over_blink;
    logic             game_reset;

    game_state_ctrl #(
        .COUNTDOWN_FRAMES (CD),
        .OVER_MIN_FRAMES  (OMIN),
        .OVER_MAX_FRAMES  (OMAX),
        .BLINK_FRAMES     (BLINK),
        .CNT_W            (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vsync       (vsync),
        .btn_start   (btn_start),
        .btn_pause   (btn_pause),
        .player_dead (player_dead),
        .game_state  (game_state),
        .frame_cnt   (frame_cnt),
        .over_blink  (over_blink),
        .game_reset  (game_reset)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int fc;
        int blink;
        int gr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic cmp(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: game rules in terms of events and unsaturated frame counts.
    int m_st = S_MENU;
    int m_fr = 0;
    bit m_vprev = 0, m_pend = 0, m_bsp = 0, m_bpp = 0;

    task automatic model(input bit r, input bit bs, input bit bp, input bit pd, input bit vs);
        exp_t e;
        bit   tk, sev, pev;
        int   fc, nxt;
        if (!r) begin
            m_st = S_MENU; m_fr = 0;
            m_vprev = 0; m_pend = 0; m_bsp = 0; m_bpp = 0;
            e.st = S_MENU; e.fc = 0; e.blink = 0; e.gr = 0;
        end else begin
            // The tick seen now comes from the vsync edge sampled one clk earlier.
            tk  = m_pend;
            m_pend  = vs && !m_vprev;
            m_vprev = vs;
            sev = bs && !m_bsp;
            pev = bp && !m_bpp;
            m_bsp = bs;
            m_bpp = bp;
            fc  = (m_fr > MAXC) ? MAXC : m_fr;
            nxt = m_st;
            case (m_st)
                S_MENU:  if (sev) nxt = S_CD;
                S_CD:    if (tk && fc == CD - 1) nxt = S_PLAY;
                S_PLAY:  nxt = pd ? S_OVER : (pev ? S_PAUSE : S_PLAY);
                S_PAUSE: if (pev || sev) nxt = S_PLAY;
                S_OVER: begin
                    if (sev && fc >= OMIN)         nxt = S_CD;
                    else if (tk && fc == OMAX - 1) nxt = S_MENU;
                end
                default: nxt = S_MENU;
            endcase
            e.gr = (nxt == S_CD && m_st != S_CD) ? 1 : 0;
            if (nxt != m_st)           m_fr = 0;
            else if (tk && m_fr < 1000) m_fr++;
            m_st = nxt;
            e.st    = m_st;
            e.fc    = (m_fr > MAXC) ? MAXC : m_fr;
            e.blink = (m_st == S_OVER && ((m_fr / BLINK) % 2) == 1) ? 1 : 0;
        end
        sb.push_back(e);
    endtask

    // One clk of stimulus: inputs change on the falling edge, DUT samples on the next rising edge.
    task automatic step(input bit r, input bit bs, input bit bp, input bit pd, input bit vs);
        @(negedge clk);
        rst = r; btn_start = bs; btn_pause = bp; player_dead = pd; vsync = vs;
        model(r, bs, bp, pd, vs);
    endtask

    task automatic frame(input bit bs, input bit bp, input bit pd);
        step(1, bs, bp, pd, 1);
        step(1, bs, bp, pd, 1);
        for (int i = 0; i < 3; i++) step(1, bs, bp, pd, 0);
    endtask

    // Directed check of the state produced by the most recent step.
    task automatic chk(input string nm, input int st, input int fc, input int gr);
        @(posedge clk);
        #2;
        cmp({nm, ".state"}, int'(game_state), st);
        cmp({nm, ".frame_cnt"}, int'(frame_cnt), fc);
        cmp({nm, ".game_reset"}, int'(game_reset), gr);
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("sb.state", int'(game_state), e.st);
                cmp("sb.frame_cnt", int'(frame_cnt), e.fc);
                cmp("sb.over_blink", int'(over_blink), e.blink);
                cmp("sb.game_reset", int'(game_reset), e.gr);
            end
        end
    end

    initial begin
        int vcnt, vper;
        bit bs, bp, pd, r, vs;

        // Reset, then idle in MENU long enough to saturate frame_cnt.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        chk("reset", S_MENU, 0, 0);
        for (int i = 0; i < 10; i++) frame(0, 0, 0);
        chk("menu_idle", S_MENU, MAXC, 0);

        // Start, countdown, play.
        step(1, 1, 0, 0, 0);
        chk("start", S_CD, 0, 1);
        for (int i = 0; i < CD; i++) frame(0, 0, 0);
        chk("countdown_done", S_PLAY, 0, 0);

        // Death and pause together: death wins.
        step(1, 0, 1, 1, 0);
        chk("dead_vs_pause", S_OVER, 0, 0);
        frame(0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("early_start", S_OVER, 1, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < OMAX - 1; i++) frame(0, 0, 0);
        chk("over_timeout", S_MENU, 0, 0);

        // Held pause gives one event; paused death is deferred.
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < CD; i++) frame(0, 0, 0);
        for (int i = 0; i < 1000; i++) step(1, 0, 1, 0, 0);
        chk("pause_held", S_PAUSE, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("unpause", S_PLAY, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("pause_again", S_PAUSE, 0, 0);
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
        chk("paused_dead", S_PAUSE, 0, 0);
        step(1, 0, 1, 1, 0);
        chk("resume_dead", S_PLAY, 0, 0);
        step(1, 0, 1, 1, 0);
        chk("dead_after_resume", S_OVER, 0, 0);

        // Restart from OVER once the minimum time has passed.
        for (int i = 0; i < OMIN; i++) frame(0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("over_restart", S_CD, 0, 1);

        // Randomized phase with occasional resets.
        bs = 1; bp = 0; pd = 0;
        vcnt = 0; vper = 6;
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 7) == 0)  bs = ~bs;
            if ($urandom_range(0, 7) == 0)  bp = ~bp;
            if ($urandom_range(0, 19) == 0) pd = ~pd;
            vs = (vcnt < 2);
            vcnt++;
            if (vcnt >= vper) begin
                vcnt = 0;
                vper = $urandom_range(4, 10);
            end
            step(r, bs, bp, pd, vs);
        end

        @(posedge clk);
        #3;
        cmp("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
